// File: rtl/uart_pkg.sv
// UART shared definitions: receiver/transmitter FSM states and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and frame configuration in, byte and status strobes out.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output rx_in, par_en, par_typ,
        input  p_data, data_valid, par_err, stop_err
    );

    modport slave (
        input  rx_in, par_en, par_typ,
        output p_data, data_valid, par_err, stop_err
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// UART RX front end: input synchronizer, bit-period counter and 3-sample mid-bit majority vote.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_i,
    input  logic run_i,
    output logic rx_s_o,
    output logic sample_bit_c,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned MID   = PRESCALE / 2;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [2:0]       samp_q;
    logic             in_window_c;

    // Two-flop synchronizer; the line idles high so reset to 1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

    // Position within the current bit; held at 0 while the receiver is idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
        end else if (!run_i || bit_end_c) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
    end

    assign in_window_c = (edge_cnt_q == CNT_W'(MID - 1)) ||
                         (edge_cnt_q == CNT_W'(MID))     ||
                         (edge_cnt_q == CNT_W'(MID + 1));

    // Capture the three samples around mid-bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q <= 3'b111;
        end else if (in_window_c) begin
            samp_q <= {samp_q[1:0], rx_s_o};
        end
    end

    assign sample_bit_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign bit_end_c    = (edge_cnt_q == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first shift register, parity/stop checks and registered outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rx_s;
    logic                  sample_bit_c;
    logic                  bit_end_c;
    logic                  run_c;
    uart_state_e           state_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;

    // The start-detect cycle already counts as the first tick of the start bit
    assign run_c = (state_q != ST_IDLE) || (rx_s == START_BIT);

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .rx_i         (bus.rx_in),
        .run_i        (run_c),
        .rx_s_o       (rx_s),
        .sample_bit_c (sample_bit_c),
        .bit_end_c    (bit_end_c)
    );

    // Frame FSM with datapath and one-cycle status strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_q   <= ST_START;
                        par_en_q  <= bus.par_en;
                        par_typ_q <= bus.par_typ;
                        par_bad_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end_c) begin
                        state_q <= (sample_bit_c == START_BIT) ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        shift_q <= {sample_bit_c, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_c) begin
                        par_bad_q <= (sample_bit_c != (^shift_q ^ par_typ_q));
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end_c) begin
                        state_q <= ST_IDLE;
                        if ((sample_bit_c == STOP_BIT) && !par_bad_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end else begin
                            stop_err_q <= (sample_bit_c != STOP_BIT);
                            par_err_q  <= par_bad_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p_data     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stop_err   = stop_err_q;

endmodule
